// File: rtl/inst_fetch.sv
// Instruction fetch stage: PC, IF/ID register, RUN/HALT control.
// Ports: clk/reset, stall, jump/branch redirects, imem A port, IF/ID outputs, status.
module inst_fetch #(
  parameter logic [4:0] RESET_PC = 5'd0,
  parameter logic [4:0] END_ADDR = 5'd31
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        jump,
  input  logic [4:0]  jump_target,
  input  logic        branch_taken,
  input  logic [4:0]  branch_target,
  output logic [4:0]  imem_addr,
  input  logic [31:0] imem_rd,
  output logic [4:0]  pc,
  output logic [31:0] if_id_instr,
  output logic [4:0]  if_id_pc_plus1,
  output logic        if_id_valid,
  output logic        halted,
  output logic [15:0] fetch_count
);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t     state;
  logic [4:0] pc_inc;
  logic       redirect;
  logic [4:0] redirect_pc;

  assign imem_addr   = pc;
  assign pc_inc      = pc + 5'd1;
  assign redirect    = jump | branch_taken;
  assign redirect_pc = jump ? jump_target : branch_target;

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= RUN;
      pc             <= RESET_PC;
      if_id_instr    <= '0;
      if_id_pc_plus1 <= '0;
      if_id_valid    <= 1'b0;
      fetch_count    <= '0;
      halted         <= 1'b0;
    end else if (redirect) begin
      // Redirect flushes IF/ID, overrides stall and leaves HALT.
      state       <= RUN;
      halted      <= 1'b0;
      pc          <= redirect_pc;
      if_id_instr <= '0;
      if_id_valid <= 1'b0;
    end else if (state == HALT) begin
      if_id_instr <= '0;
      if_id_valid <= 1'b0;
    end else if (!stall) begin
      pc             <= pc_inc;
      if_id_instr    <= imem_rd;
      if_id_pc_plus1 <= pc_inc;
      if_id_valid    <= 1'b1;
      if (fetch_count != 16'hFFFF)
        fetch_count <= fetch_count + 16'd1;
      // The last word is still captured; stop on the same edge.
      if (pc == END_ADDR) begin
        state  <= HALT;
        halted <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed steps push expectations,
// a monitor pops and compares one record per clock.
module tb_inst_fetch;

  typedef struct packed {
    logic        dut;
    logic [4:0]  pc;
    logic [31:0] instr;
    logic [4:0]  pp1;
    logic        v;
    logic        h;
    logic [15:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b;
  logic        stall, jump, branch_taken;
  logic [4:0]  jump_target, branch_target;
  logic [31:0] mem [32];

  logic [4:0]  addr_a, pc_a, pp1_a;
  logic [31:0] rd_a, instr_a;
  logic        v_a, h_a;
  logic [15:0] cnt_a;

  logic [4:0]  addr_b, pc_b, pp1_b;
  logic [31:0] rd_b, instr_b;
  logic        v_b, h_b;
  logic [15:0] cnt_b;

  assign rd_a = mem[addr_a];
  assign rd_b = mem[addr_b];

  inst_fetch #(.RESET_PC(5'd0), .END_ADDR(5'd31)) dut_a (
    .clk(clk), .reset(rst_a), .stall(stall),
    .jump(jump), .jump_target(jump_target),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_addr(addr_a), .imem_rd(rd_a), .pc(pc_a),
    .if_id_instr(instr_a), .if_id_pc_plus1(pp1_a),
    .if_id_valid(v_a), .halted(h_a), .fetch_count(cnt_a)
  );

  inst_fetch #(.RESET_PC(5'd0), .END_ADDR(5'd4)) dut_b (
    .clk(clk), .reset(rst_b), .stall(stall),
    .jump(jump), .jump_target(jump_target),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_addr(addr_b), .imem_rd(rd_b), .pc(pc_b),
    .if_id_instr(instr_b), .if_id_pc_plus1(pp1_b),
    .if_id_valid(v_b), .halted(h_b), .fetch_count(cnt_b)
  );

  function automatic logic [31:0] w(input int i);
    if (i == 0) return 32'h2010000F;
    if (i == 1) return 32'h20110019;
    return 32'hC0DE0000 | i;
  endfunction

  function automatic exp_t mk(input logic [4:0] p, input logic [31:0] ins,
                              input logic [4:0] pp, input logic v,
                              input logic h, input logic [15:0] c);
    exp_t e;
    e.dut = 1'b0; e.pc = p; e.instr = ins; e.pp1 = pp;
    e.v = v; e.h = h; e.cnt = c;
    return e;
  endfunction

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // d selects the DUT under test; the other is held in reset.
  task automatic step(input logic d, input logic r, input logic s,
                      input logic j, input logic [4:0] jt,
                      input logic b, input logic [4:0] bt,
                      input exp_t e);
    exp_t x;
    @(negedge clk); #1;
    rst_a = d ? 1'b1 : r;
    rst_b = d ? r : 1'b1;
    stall = s; jump = j; jump_target = jt;
    branch_taken = b; branch_target = bt;
    x = e; x.dut = d;
    sb.push_back(x);
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      if (sb.size() > 0) begin
        exp_t e, a;
        e = sb.pop_front();
        a.dut = e.dut;
        if (e.dut) begin
          a.pc = pc_b; a.instr = instr_b; a.pp1 = pp1_b;
          a.v = v_b; a.h = h_b; a.cnt = cnt_b;
        end else begin
          a.pc = pc_a; a.instr = instr_a; a.pp1 = pp1_a;
          a.v = v_a; a.h = h_a; a.cnt = cnt_a;
        end
        n_cmp++;
        if (a !== e) begin
          n_bad++;
          $display("FAIL state dut%0d: got pc=%0d ins=%h pp1=%0d v=%b h=%b cnt=%0d want pc=%0d ins=%h pp1=%0d v=%b h=%b cnt=%0d",
                   e.dut, a.pc, a.instr, a.pp1, a.v, a.h, a.cnt,
                   e.pc, e.instr, e.pp1, e.v, e.h, e.cnt);
        end
        n_cmp++;
        if ((e.dut ? addr_b : addr_a) !== e.pc) begin
          n_bad++;
          $display("FAIL imem_addr dut%0d: got %0d want %0d",
                   e.dut, e.dut ? addr_b : addr_a, e.pc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = w(i);
    rst_a = 1'b1; rst_b = 1'b1;
    stall = 1'b0; jump = 1'b0; branch_taken = 1'b0;
    jump_target = '0; branch_target = '0;

    // DUT B: END_ADDR = 4, halt then jump back.
    step(1, 1, 0, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0));
    step(1, 0, 0, 0, 0, 0, 0, mk(1, w(0), 1, 1, 0, 1));
    step(1, 0, 0, 0, 0, 0, 0, mk(2, w(1), 2, 1, 0, 2));
    step(1, 0, 0, 0, 0, 0, 0, mk(3, w(2), 3, 1, 0, 3));
    step(1, 0, 0, 0, 0, 0, 0, mk(4, w(3), 4, 1, 0, 4));
    step(1, 0, 0, 0, 0, 0, 0, mk(5, w(4), 5, 1, 1, 5));
    step(1, 0, 0, 0, 0, 0, 0, mk(5, 0, 5, 0, 1, 5));
    step(1, 0, 1, 0, 0, 0, 0, mk(5, 0, 5, 0, 1, 5));
    step(1, 0, 0, 0, 0, 0, 0, mk(5, 0, 5, 0, 1, 5));
    step(1, 0, 0, 1, 0, 0, 0, mk(0, 0, 5, 0, 0, 5));
    step(1, 0, 0, 0, 0, 0, 0, mk(1, w(0), 1, 1, 0, 6));

    // DUT A: END_ADDR = 31.
    step(0, 1, 0, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0));
    step(0, 0, 0, 0, 0, 0, 0, mk(1, 32'h2010000F, 1, 1, 0, 1));
    step(0, 0, 0, 0, 0, 0, 0, mk(2, 32'h20110019, 2, 1, 0, 2));
    step(0, 0, 0, 0, 0, 0, 0, mk(3, w(2), 3, 1, 0, 3));
    // stall three cycles at pc=3
    step(0, 0, 1, 0, 0, 0, 0, mk(3, w(2), 3, 1, 0, 3));
    step(0, 0, 1, 0, 0, 0, 0, mk(3, w(2), 3, 1, 0, 3));
    step(0, 0, 1, 0, 0, 0, 0, mk(3, w(2), 3, 1, 0, 3));
    step(0, 0, 0, 0, 0, 0, 0, mk(4, w(3), 4, 1, 0, 4));
    step(0, 0, 0, 0, 0, 0, 0, mk(5, w(4), 5, 1, 0, 5));
    // branch at pc=5 while stalled
    step(0, 0, 1, 0, 0, 1, 12, mk(12, 0, 5, 0, 0, 5));
    step(0, 0, 0, 0, 0, 0, 0, mk(13, w(12), 13, 1, 0, 6));
    // jump beats branch
    step(0, 0, 0, 1, 7, 1, 20, mk(7, 0, 13, 0, 0, 6));
    step(0, 0, 0, 0, 0, 0, 0, mk(8, w(7), 8, 1, 0, 7));
    // redirect to END_ADDR does not halt; fetching it does
    step(0, 0, 0, 1, 31, 0, 0, mk(31, 0, 8, 0, 0, 7));
    step(0, 0, 0, 0, 0, 0, 0, mk(0, w(31), 0, 1, 1, 8));
    step(0, 0, 0, 0, 0, 0, 0, mk(0, 0, 0, 0, 1, 8));
    step(0, 0, 1, 0, 0, 0, 0, mk(0, 0, 0, 0, 1, 8));
    // reset in HALT overrides a simultaneous jump
    step(0, 1, 1, 1, 9, 1, 17, mk(0, 0, 0, 0, 0, 0));
    step(0, 0, 0, 0, 0, 0, 0, mk(1, w(0), 1, 1, 0, 1));

    @(negedge clk); #1;
    rst_a = 1'b1;
    @(posedge clk); #3;
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
